// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low a..g patterns (index 0=a ... 6=g),
// special BCD codes and the capture FSM state type.
package seg7_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b1100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0001100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_ERR   = 4'hF;
  localparam logic [3:0] BCD_BLANK = 4'hA;

  typedef enum logic {
    ST_SYNC,
    ST_COLLECT
  } capState_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to BCD lookup with an error flag.
// Build option: SEG7_CAPTURE_BLANK_EN makes the all-off pattern decode to
// BCD_BLANK without error; otherwise all-off is treated as invalid.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [0:6] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  // Look the pattern up; anything not in the table is an error code.
  always_comb begin
    o_bcd = BCD_ERR;
    o_err = 1'b1;
    case (i_seg)
      SEG_0: begin o_bcd = 4'd0; o_err = 1'b0; end
      SEG_1: begin o_bcd = 4'd1; o_err = 1'b0; end
      SEG_2: begin o_bcd = 4'd2; o_err = 1'b0; end
      SEG_3: begin o_bcd = 4'd3; o_err = 1'b0; end
      SEG_4: begin o_bcd = 4'd4; o_err = 1'b0; end
      SEG_5: begin o_bcd = 4'd5; o_err = 1'b0; end
      SEG_6: begin o_bcd = 4'd6; o_err = 1'b0; end
      SEG_7: begin o_bcd = 4'd7; o_err = 1'b0; end
      SEG_8: begin o_bcd = 4'd8; o_err = 1'b0; end
      SEG_9: begin o_bcd = 4'd9; o_err = 1'b0; end
`ifdef SEG7_CAPTURE_BLANK_EN
      SEG_BLANK: begin o_bcd = BCD_BLANK; o_err = 1'b0; end
`endif
      default: begin
        o_bcd = BCD_ERR;
        o_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment bus capture: synchronizes a multiplexed active-low display bus,
// qualifies each digit for stability, decodes it to BCD and assembles frames
// presented on a valid/ready port with a sticky overflow flag.
// Build option: SEG7_CAPTURE_BLANK_EN (handled inside seg7_decode).
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDIG-1:0]   digit_sel,
  input  logic [0:6]        display,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   err_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam int              IDX_W    = $clog2(NDIG);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [NDIG-1:0]   r_selMeta, r_selSync, r_selPrev;
  logic [0:6]        r_segMeta, r_segSync, r_segPrev;
  logic [CNT_W-1:0]  r_stableCnt;
  capState_t         r_state, w_stateNext;
  logic [NDIG-1:0]   r_mask, w_maskNext;
  logic [4*NDIG-1:0] r_digits, w_digitsNext;
  logic [NDIG-1:0]   r_errs, w_errsNext;
  logic [4*NDIG-1:0] r_bcdOut;
  logic [NDIG-1:0]   r_errOut;
  logic              r_outValid, r_overflow;

  logic              w_sampleSame, w_strobeOk, w_accept;
  logic [IDX_W-1:0]  w_digitIdx;
  logic [NDIG-1:0]   w_idxBit;
  logic [3:0]        w_decBcd;
  logic              w_decErr;
  logic              w_store, w_frameDone;

  // Two-flop synchronizer; idles at all ones (no strobe, segments off).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_selMeta <= '1;
      r_selSync <= '1;
      r_segMeta <= '1;
      r_segSync <= '1;
    end else begin
      r_selMeta <= digit_sel;
      r_selSync <= r_selMeta;
      r_segMeta <= display;
      r_segSync <= r_segMeta;
    end
  end

  assign w_sampleSame = (r_selSync == r_selPrev) && (r_segSync == r_segPrev);
  assign w_strobeOk   = $onehot(~r_selSync);
  assign w_accept     = w_sampleSame && w_strobeOk && (r_stableCnt == CNT_LAST);

  // Stability counter: restarts on any change or bad strobe, saturates so a
  // steady pattern is accepted only once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_selPrev   <= '1;
      r_segPrev   <= '1;
      r_stableCnt <= '0;
    end else begin
      r_selPrev <= r_selSync;
      r_segPrev <= r_segSync;
      if (!w_sampleSame || !w_strobeOk) begin
        r_stableCnt <= '0;
      end else if (r_stableCnt != CNT_MAX) begin
        r_stableCnt <= r_stableCnt + 1'b1;
      end
    end
  end

  // Convert the active-low strobe into a digit index and a one-hot bit.
  always_comb begin
    w_digitIdx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!r_selSync[i]) w_digitIdx = IDX_W'(i);
    end
  end

  assign w_idxBit = ~r_selSync;

  seg7_decode u_decode (
    .i_seg (r_segSync),
    .o_bcd (w_decBcd),
    .o_err (w_decErr)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_SYNC;
    else       r_state <= w_stateNext;
  end

  // FSM next state: leave SYNC on digit 0, return once the mask fills.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_SYNC:    if (w_accept && (w_digitIdx == '0)) w_stateNext = ST_COLLECT;
      ST_COLLECT: if (w_frameDone) w_stateNext = ST_SYNC;
      default:    w_stateNext = ST_SYNC;
    endcase
  end

  // FSM outputs: which acceptances are stored and when the frame completes.
  always_comb begin
    w_store      = 1'b0;
    w_frameDone  = 1'b0;
    w_maskNext   = r_mask;
    w_digitsNext = r_digits;
    w_errsNext   = r_errs;
    case (r_state)
      ST_SYNC:    w_store = w_accept && (w_digitIdx == '0);
      ST_COLLECT: w_store = w_accept;
      default:    w_store = 1'b0;
    endcase
    if (w_store) begin
      w_maskNext = r_mask | w_idxBit;
      for (int i = 0; i < NDIG; i++) begin
        if (w_idxBit[i]) begin
          w_digitsNext[4*i +: 4] = w_decBcd;
          w_errsNext[i]          = w_decErr;
        end
      end
    end
    w_frameDone = (r_state == ST_COLLECT) && w_store && (&w_maskNext);
  end

  // Partial-frame storage; the mask clears as the frame completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask   <= '0;
      r_digits <= '0;
      r_errs   <= '0;
    end else begin
      r_mask   <= w_frameDone ? '0 : w_maskNext;
      r_digits <= w_digitsNext;
      r_errs   <= w_errsNext;
    end
  end

  // Output holding register and handshake; a frame finishing while the
  // held one is still pending is dropped and flagged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcdOut   <= '0;
      r_errOut   <= '0;
      r_outValid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_frameDone) begin
      if (!r_outValid || out_ready) begin
        r_bcdOut   <= w_digitsNext;
        r_errOut   <= w_errsNext;
        r_outValid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_outValid && out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign bcd_out   = r_bcdOut;
  assign err_mask  = r_errOut;
  assign out_valid = r_outValid;
  assign overflow  = r_overflow;

endmodule
